alu_stage: RTL and testbench

ALU_STAGE -- requirements
Module: alu_stage

---
 rtl/alu_stage_pkg.sv | 29 ++
 rtl/cond_eval.sv | 39 +++
 rtl/alu_stage.sv | 110 +++++++++++
 tb/tb_alu_stage.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_stage_pkg.sv
// rtl/alu_stage_pkg.sv - shared opcode, condition-code and cpsr flag definitions
package alu_stage_pkg;

    typedef enum logic [3:0] {
        OP_AND = 4'h0, OP_EOR = 4'h1, OP_SUB = 4'h2, OP_RSB = 4'h3,
        OP_ADD = 4'h4, OP_ADC = 4'h5, OP_SBC = 4'h6, OP_RSC = 4'h7,
        OP_TST = 4'h8, OP_TEQ = 4'h9, OP_CMP = 4'hA, OP_CMN = 4'hB,
        OP_ORR = 4'hC, OP_MOV = 4'hD, OP_BIC = 4'hE, OP_MVN = 4'hF
    } opcode_e;

    typedef enum logic [3:0] {
        COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
        COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
        COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
        COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
    } cond_e;

    localparam int FLAG_N   = 15;
    localparam int FLAG_Z   = 14;
    localparam int FLAG_C   = 13;
    localparam int FLAG_V   = 12;
    localparam int FLAG_LSB = FLAG_V;

    // TST/TEQ/CMP/CMN occupy 8..B: they always set flags and never write rd
    function automatic logic is_test_op(input logic [3:0] op);
        return op[3:2] == 2'b10;
    endfunction

endpackage

// File: rtl/cond_eval.sv
// rtl/cond_eval.sv - combinational ARM condition-code evaluation
module cond_eval
    import alu_stage_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       pass
);

    logic n, z, c, v;

    assign n = flags[FLAG_N - FLAG_LSB];
    assign z = flags[FLAG_Z - FLAG_LSB];
    assign c = flags[FLAG_C - FLAG_LSB];
    assign v = flags[FLAG_V - FLAG_LSB];

    always_comb begin
        pass = 1'b0;
        case (cond_e'(cond))
            COND_EQ: pass = z;
            COND_NE: pass = !z;
            COND_CS: pass = c;
            COND_CC: pass = !c;
            COND_MI: pass = n;
            COND_PL: pass = !n;
            COND_VS: pass = v;
            COND_VC: pass = !v;
            COND_HI: pass = c && !z;
            COND_LS: pass = !c || z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = !z && (n == v);
            COND_LE: pass = z || (n != v);
            COND_AL: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_stage.sv
// rtl/alu_stage.sv - single-cycle conditional ALU pipeline stage with cpsr
module alu_stage
    import alu_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  cond,
    input  logic [3:0]  opcode,
    input  logic        s_bit,
    input  logic [3:0]  rd,
    input  logic [15:0] op1,
    input  logic [15:0] op2,
    input  logic        shifter_carry,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_result,
    output logic [3:0]  out_rd,
    output logic        out_we,
    output logic [15:0] cpsr
);

    logic [3:0]  flags;
    logic        pass;
    logic        accept;
    logic        arith;
    logic [15:0] x;
    logic [15:0] y;
    logic        cin;
    logic [16:0] sum;
    logic [15:0] alu_result;
    logic [3:0]  new_flags;
    logic        update_flags;
    logic        we;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign cpsr     = {flags, 12'h000};

    cond_eval u_cond_eval (
        .cond  (cond),
        .flags (flags),
        .pass  (pass)
    );

    // Every subtract is x + ~y + cin so that bit 16 is NOT-borrow
    always_comb begin
        arith = 1'b1;
        x     = op1;
        y     = op2;
        cin   = 1'b0;
        case (opcode_e'(opcode))
            OP_SUB, OP_CMP: begin y = ~op2; cin = 1'b1; end
            OP_RSB:         begin x = op2; y = ~op1; cin = 1'b1; end
            OP_ADD, OP_CMN: cin = 1'b0;
            OP_ADC:         cin = flags[FLAG_C - FLAG_LSB];
            OP_SBC:         begin y = ~op2; cin = flags[FLAG_C - FLAG_LSB]; end
            OP_RSC:         begin x = op2; y = ~op1; cin = flags[FLAG_C - FLAG_LSB]; end
            default:        arith = 1'b0;
        endcase
    end

    assign sum = {1'b0, x} + {1'b0, y} + {16'h0000, cin};

    always_comb begin
        alu_result = sum[15:0];
        case (opcode_e'(opcode))
            OP_AND, OP_TST: alu_result = op1 & op2;
            OP_EOR, OP_TEQ: alu_result = op1 ^ op2;
            OP_ORR:         alu_result = op1 | op2;
            OP_MOV:         alu_result = op2;
            OP_BIC:         alu_result = op1 & ~op2;
            OP_MVN:         alu_result = ~op2;
            default:        alu_result = sum[15:0];
        endcase
    end

    always_comb begin
        new_flags[FLAG_N - FLAG_LSB] = alu_result[15];
        new_flags[FLAG_Z - FLAG_LSB] = (alu_result == 16'h0000);
        new_flags[FLAG_C - FLAG_LSB] = arith ? sum[16] : shifter_carry;
        new_flags[FLAG_V - FLAG_LSB] = arith ? ((x[15] == y[15]) && (sum[15] != x[15]))
                                             : flags[FLAG_V - FLAG_LSB];
    end

    assign update_flags = pass && (s_bit || is_test_op(opcode));
    assign we           = pass && !is_test_op(opcode);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_result <= 16'h0000;
            out_rd     <= 4'h0;
            out_we     <= 1'b0;
            flags      <= 4'h0;
        end else if (accept) begin
            out_valid  <= 1'b1;
            out_result <= alu_result;
            out_rd     <= rd;
            out_we     <= we;
            if (update_flags) begin
                flags <= new_flags;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_stage.sv
// tb/tb_alu_stage.sv - self-checking bench for alu_stage against a behavioural model
module tb_alu_stage;
    import alu_stage_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  cond;
    logic [3:0]  opcode;
    logic        s_bit;
    logic [3:0]  rd;
    logic [15:0] op1;
    logic [15:0] op2;
    logic        shifter_carry;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_result;
    logic [3:0]  out_rd;
    logic        out_we;
    logic [15:0] cpsr;

    int n_asserts = 0;
    int n_fail    = 0;
    bit m_n, m_z, m_c, m_v;

    alu_stage dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .cond          (cond),
        .opcode        (opcode),
        .s_bit         (s_bit),
        .rd            (rd),
        .op1           (op1),
        .op2           (op2),
        .shifter_carry (shifter_carry),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_result    (out_result),
        .out_rd        (out_rd),
        .out_we        (out_we),
        .cpsr          (cpsr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] m_cpsr();
        return {m_n, m_z, m_c, m_v, 12'h000};
    endfunction

    function automatic bit cond_ok(input logic [3:0] c);
        case (c)
            4'h0: return m_z;
            4'h1: return !m_z;
            4'h2: return m_c;
            4'h3: return !m_c;
            4'h4: return m_n;
            4'h5: return !m_n;
            4'h6: return m_v;
            4'h7: return !m_v;
            4'h8: return m_c && !m_z;
            4'h9: return !m_c || m_z;
            4'hA: return m_n == m_v;
            4'hB: return m_n != m_v;
            4'hC: return !m_z && (m_n == m_v);
            4'hD: return m_z || (m_n != m_v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Plain integer arithmetic: carry from the unsigned sum, overflow from the signed sum
    task automatic model(input logic [3:0] c, input logic [3:0] op, input logic s,
                         input logic [15:0] a, input logic [15:0] b, input logic sc,
                         output logic [15:0] res, output logic we);
        int ua, ub, sa, sb, u, sv, k;
        bit ar, cc, vv, pass, test;
        ua = a; ub = b; sa = $signed(a); sb = $signed(b);
        k  = m_c ? 0 : 1;
        ar = 1'b1; u = 0; sv = 0; cc = 1'b0;
        case (op)
            4'h0, 4'h8: begin u = ua & ub; ar = 1'b0; end
            4'h1, 4'h9: begin u = ua ^ ub; ar = 1'b0; end
            4'hC:       begin u = ua | ub; ar = 1'b0; end
            4'hD:       begin u = ub; ar = 1'b0; end
            4'hE:       begin u = ua & ~ub; ar = 1'b0; end
            4'hF:       begin u = ~ub; ar = 1'b0; end
            4'h2, 4'hA: begin u = ua - ub;     sv = sa - sb;     cc = (u >= 0); end
            4'h3:       begin u = ub - ua;     sv = sb - sa;     cc = (u >= 0); end
            4'h4, 4'hB: begin u = ua + ub;     sv = sa + sb;     cc = (u > 65535); end
            4'h5:       begin u = ua + ub + (1 - k); sv = sa + sb + (1 - k); cc = (u > 65535); end
            4'h6:       begin u = ua - ub - k; sv = sa - sb - k; cc = (u >= 0); end
            default:    begin u = ub - ua - k; sv = sb - sa - k; cc = (u >= 0); end
        endcase
        res  = 16'(u);
        vv   = (sv > 32767) || (sv < -32768);
        pass = cond_ok(c);
        test = (op >= 4'h8) && (op <= 4'hB);
        we   = pass && !test;
        if (pass && (s || test)) begin
            m_n = res[15];
            m_z = (res == 16'h0000);
            m_c = ar ? cc : sc;
            if (ar) m_v = vv;
        end
    endtask

    task automatic drive(input logic [3:0] c, input logic [3:0] op, input logic s,
                         input logic [3:0] r, input logic [15:0] a, input logic [15:0] b,
                         input logic sc);
        in_valid = 1'b1; cond = c; opcode = op; s_bit = s; rd = r;
        op1 = a; op2 = b; shifter_carry = sc;
    endtask

    task automatic check_beat(input string tag, input logic [3:0] r,
                              input logic [15:0] er, input logic ew);
        check({tag, ".valid"}, 32'(out_valid), 32'd1);
        check({tag, ".rd"},    32'(out_rd),    32'(r));
        check({tag, ".we"},    32'(out_we),    32'(ew));
        check({tag, ".cpsr"},  32'(cpsr),      32'(m_cpsr()));
        if (ew) check({tag, ".result"}, 32'(out_result), 32'(er));
    endtask

    logic [15:0] last_res;
    logic        last_we;

    task automatic issue(input string tag, input logic [3:0] c, input logic [3:0] op,
                         input logic s, input logic [3:0] r, input logic [15:0] a,
                         input logic [15:0] b, input logic sc);
        logic [15:0] er;
        logic        ew;
        @(negedge clk);
        drive(c, op, s, r, a, b, sc);
        out_ready = 1'b1;
        model(c, op, s, a, b, sc, er, ew);
        @(posedge clk);
        #1;
        check_beat(tag, r, er, ew);
        last_res = er;
        last_we  = ew;
    endtask

    initial begin
        logic [15:0] er, held_res;
        logic        ew;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        cond = 4'h0; opcode = 4'h0; s_bit = 1'b0; rd = 4'h0;
        op1 = 16'h0; op2 = 16'h0; shifter_carry = 1'b0;
        m_n = 0; m_z = 0; m_c = 0; m_v = 0;
        #1;
        check("rst.valid",    32'(out_valid),  32'd0);
        check("rst.result",   32'(out_result), 32'd0);
        check("rst.we",       32'(out_we),     32'd0);
        check("rst.cpsr",     32'(cpsr),       32'd0);
        check("rst.in_ready", 32'(in_ready),   32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("post_rst.in_ready", 32'(in_ready), 32'd1);

        issue("adds_ovf", COND_AL, OP_ADD, 1'b1, 4'h1, 16'h7FFF, 16'h0001, 1'b0);
        check("adds_ovf.result_const", 32'(out_result), 32'h8000);
        check("adds_ovf.cpsr_const",   32'(cpsr),       32'h9000);

        issue("cmp_eq", COND_AL, OP_CMP, 1'b0, 4'h2, 16'h0005, 16'h0005, 1'b0);
        check("cmp_eq.cpsr_const", 32'(cpsr), 32'h6000);
        check("cmp_eq.we_const",   32'(out_we), 32'd0);
        issue("subeq", COND_EQ, OP_SUB, 1'b0, 4'h3, 16'h0009, 16'h0004, 1'b0);
        check("subeq.result_const", 32'(out_result), 32'h0005);
        check("subeq.we_const",     32'(out_we), 32'd1);

        issue("movne", COND_NE, OP_MOV, 1'b1, 4'h4, 16'h1111, 16'h2222, 1'b0);
        check("movne.we_const",   32'(out_we), 32'd0);
        check("movne.cpsr_const", 32'(cpsr),   32'h6000);

        issue("set_v", COND_AL, OP_ADD, 1'b1, 4'h5, 16'h7FFF, 16'h0001, 1'b0);
        issue("orrs_zero", COND_AL, OP_ORR, 1'b1, 4'h6, 16'h0000, 16'h0000, 1'b1);
        check("orrs_zero.cpsr_const", 32'(cpsr), 32'h7000);

        issue("never", COND_NV, OP_ADD, 1'b1, 4'h7, 16'h0001, 16'h0001, 1'b0);

        // Stall: the held beat and cpsr must not move while out_ready is low
        issue("stall_a", COND_AL, OP_SUB, 1'b1, 4'h8, 16'h0003, 16'h0007, 1'b0);
        held_res = last_res;
        @(negedge clk);
        drive(COND_AL, OP_EOR, 1'b1, 4'h9, 16'hF0F0, 16'h0FF0, 1'b1);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("stall.in_ready", 32'(in_ready),   32'd0);
            check("stall.valid",    32'(out_valid),  32'd1);
            check("stall.result",   32'(out_result), 32'(held_res));
            check("stall.rd",       32'(out_rd),     32'h8);
            check("stall.cpsr",     32'(cpsr),       32'(m_cpsr()));
        end
        @(negedge clk);
        out_ready = 1'b1;
        model(COND_AL, OP_EOR, 1'b1, 16'hF0F0, 16'h0FF0, 1'b1, er, ew);
        @(posedge clk);
        #1;
        check_beat("stall_b", 4'h9, er, ew);

        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("drain.valid", 32'(out_valid), 32'd0);

        issue("pre_rst", COND_AL, OP_MVN, 1'b1, 4'hA, 16'h0000, 16'h0000, 1'b1);
        #1;
        out_ready = 1'b0;
        reset = 1'b1;
        #1;
        check("async_rst.valid",    32'(out_valid),  32'd0);
        check("async_rst.cpsr",     32'(cpsr),       32'd0);
        check("async_rst.result",   32'(out_result), 32'd0);
        check("async_rst.we",       32'(out_we),     32'd0);
        check("async_rst.in_ready", 32'(in_ready),   32'd1);
        @(posedge clk);
        #1;
        check("rst_no_accept.valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        m_n = 0; m_z = 0; m_c = 0; m_v = 0;
        issue("after_rst", COND_AL, OP_ADD, 1'b1, 4'hB, 16'hFFFF, 16'h0002, 1'b0);

        for (int i = 0; i < 300; i++) begin
            issue("rand", 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                  16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                in_valid = 1'b0;
                @(posedge clk);
                #1;
                check("rand_drain.valid", 32'(out_valid), 32'd0);
            end
        end

        @(negedge clk);
        in_valid = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
